// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16-style control path: opcodes, ext codes,
// condition codes, ALU controls, ALU B-source selects, flag indices, states.
package cr16_pkg;

  // op field [15:12]
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  // ext field [7:4]; R-type ALU ext codes share the immediate opcode values
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_MOV   = 4'b1101;

  // cond field [11:8]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;
  localparam logic [2:0] ALU_CMP   = 3'b110;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_ONE   = 2'b10;
  localparam logic [1:0] SRCB_IMMHI = 2'b11;

  localparam int unsigned FLAG_N = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [7:0] {
    S_FETCH   = 8'b0000_0001,
    S_DECODE  = 8'b0000_0010,
    S_EXEC    = 8'b0000_0100,
    S_LD_WAIT = 8'b0000_1000,
    S_LD_WB   = 8'b0001_0000,
    S_ST_WAIT = 8'b0010_0000,
    S_BRANCH  = 8'b0100_0000,
    S_JUMP    = 8'b1000_0000
  } state_t;

  // True for every instruction completed by a single EXEC cycle.
  function automatic logic is_alu_instr(input logic [3:0] op, input logic [3:0] ext);
    logic hit;
    hit = 1'b0;
    if (op == OP_RTYPE) begin
      case (ext)
        EXT_ADD, EXT_SUB, EXT_CMP, EXT_AND, EXT_OR, EXT_XOR, EXT_MOV: hit = 1'b1;
        default: hit = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_SUBI, OP_CMPI, OP_ANDI, OP_ORI, OP_XORI, OP_MOVI, OP_LUI: hit = 1'b1;
        default: hit = 1'b0;
      endcase
    end
    return hit;
  endfunction

  // ALU control from the R-type ext code or the immediate opcode.
  function automatic logic [2:0] alu_for(input logic [3:0] code);
    logic [2:0] alu;
    case (code)
      OP_ADDI: alu = ALU_ADD;
      OP_SUBI: alu = ALU_SUB;
      OP_CMPI: alu = ALU_CMP;
      OP_ANDI: alu = ALU_AND;
      OP_ORI:  alu = ALU_OR;
      OP_XORI: alu = ALU_XOR;
      default: alu = ALU_PASSB;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// Evaluates a branch/jump condition code against the PSR flags.
module cr16_cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flag,
  output logic       taken
);

  logic unused_flags;
  assign unused_flags = ^{flag[FLAG_F], flag[FLAG_L]};

  // Condition decode
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flag[FLAG_Z];
      COND_NE: taken = !flag[FLAG_Z];
      COND_CS: taken = flag[FLAG_C];
      COND_CC: taken = !flag[FLAG_C];
      COND_GT: taken = flag[FLAG_N];
      COND_LE: taken = !flag[FLAG_N];
      COND_LT: taken = !flag[FLAG_N] && !flag[FLAG_Z];
      COND_GE: taken = flag[FLAG_N] || flag[FLAG_Z];
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cr16_control_fsm.sv
// Multicycle control FSM for the CR16-style datapath, with memory
// handshake watchdog and retired-instruction counter.
module cr16_control_fsm
  import cr16_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic [4:0]       flag,
  input  logic             mem_ready,
  output logic             pcen,
  output logic             irwrite,
  output logic             regwrt,
  output logic             flag_en,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             pc_mux,
  output logic             im_mux,
  output logic [1:0]       alusrcb,
  output logic [2:0]       alucont,
  output logic             branch,
  output logic             jump,
  output logic             jal,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_LIMIT[WAIT_W-1:0];

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting, retire, cond_taken, at_limit;
  logic [3:0]        op, cond, ext, alu_code;
  logic              unused_rsrc;

  assign op          = instr[15:12];
  assign cond        = instr[11:8];
  assign ext         = instr[7:4];
  assign unused_rsrc = ^instr[3:0];
  assign alu_code    = (op == OP_RTYPE) ? ext : op;
  assign at_limit    = (wait_cnt == WAIT_MAX);

  cr16_cond_eval u_cond_eval (
    .cond  (cond),
    .flag  (flag),
    .taken (cond_taken)
  );

  // State register, memory-wait watchdog counter and retired counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || mem_err) begin
        wait_cnt <= '0;
      end else if (waiting && !mem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (retire) begin
        retired <= retired + 1'b1;
      end
    end
  end

  // Next-state and output decode; everything is held at zero during reset
  always_comb begin
    state_next = state;
    waiting    = 1'b0;
    retire     = 1'b0;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrt     = 1'b0;
    flag_en    = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    pc_mux     = 1'b0;
    im_mux     = 1'b0;
    alusrcb    = SRCB_REG;
    alucont    = ALU_ADD;
    branch     = 1'b0;
    jump       = 1'b0;
    jal        = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    if (reset) begin
      state_next = S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          waiting = 1'b1;
          memread = 1'b1;
          alusrcb = SRCB_ONE;
          alucont = ALU_ADD;
          if (mem_ready) begin
            irwrite    = 1'b1;
            pcen       = 1'b1;
            state_next = S_DECODE;
          end else if (at_limit) begin
            mem_err    = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_DECODE: begin
          if (is_alu_instr(op, ext)) begin
            state_next = S_EXEC;
          end else if (op == OP_BCOND) begin
            state_next = S_BRANCH;
          end else if (op == OP_MEM && ext == EXT_LOAD) begin
            state_next = S_LD_WAIT;
          end else if (op == OP_MEM && ext == EXT_STOR) begin
            state_next = S_ST_WAIT;
          end else if (op == OP_MEM && (ext == EXT_JCOND || ext == EXT_JAL)) begin
            state_next = S_JUMP;
          end else begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_EXEC: begin
          alucont    = alu_for(alu_code);
          alusrcb    = (op == OP_RTYPE) ? SRCB_REG
                     : (op == OP_LUI)   ? SRCB_IMMHI : SRCB_IMM;
          im_mux     = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
          flag_en    = (alucont == ALU_ADD) || (alucont == ALU_SUB) || (alucont == ALU_CMP);
          regwrt     = (alucont != ALU_CMP);
          regdst     = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_LD_WAIT: begin
          waiting = 1'b1;
          memread = 1'b1;
          pc_mux  = 1'b1;
          if (mem_ready) begin
            state_next = S_LD_WB;
          end else if (at_limit) begin
            mem_err    = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_LD_WB: begin
          regwrt     = 1'b1;
          memtoreg   = 1'b1;
          regdst     = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_ST_WAIT: begin
          waiting  = 1'b1;
          memwrite = 1'b1;
          pc_mux   = 1'b1;
          if (mem_ready) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else if (at_limit) begin
            mem_err    = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_BRANCH: begin
          branch     = cond_taken;
          pcen       = cond_taken;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_JUMP: begin
          if (ext == EXT_JAL) begin
            jal    = 1'b1;
            regwrt = 1'b1;
            regdst = 1'b1;
            jump   = 1'b1;
            pcen   = 1'b1;
          end else begin
            jump = cond_taken;
            pcen = cond_taken;
          end
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Scoreboard bench for cr16_control_fsm: an instruction-level model expands
// each random instruction into its expected per-cycle control outputs.
module tb_cr16_control_fsm;

  localparam int WL = 15;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic [4:0]  flag;
  logic        mem_ready;
  logic        pcen, irwrite, regwrt, flag_en, memread, memwrite, memtoreg;
  logic        regdst, pc_mux, im_mux, branch, jump, jal, illegal, mem_err;
  logic [1:0]  alusrcb;
  logic [2:0]  alucont;
  logic [15:0] retired;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       regwrt;
    logic       flag_en;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       pc_mux;
    logic       im_mux;
    logic [1:0] alusrcb;
    logic [2:0] alucont;
    logic       branch;
    logic       jump;
    logic       jal;
    logic       illegal;
    logic       mem_err;
  } outs_t;

  typedef struct {
    outs_t       o;
    logic [15:0] ret;
    string       tag;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [15:0] ret_m;
  int          checks;
  int          failures;

  cr16_control_fsm #(.WAIT_LIMIT(15), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .flag      (flag),
    .mem_ready (mem_ready),
    .pcen      (pcen),
    .irwrite   (irwrite),
    .regwrt    (regwrt),
    .flag_en   (flag_en),
    .memread   (memread),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .regdst    (regdst),
    .pc_mux    (pc_mux),
    .im_mux    (im_mux),
    .alusrcb   (alusrcb),
    .alucont   (alucont),
    .branch    (branch),
    .jump      (jump),
    .jal       (jal),
    .illegal   (illegal),
    .mem_err   (mem_err),
    .retired   (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------

  function automatic string mnem(input logic [15:0] ins);
    logic [3:0] op, ext;
    op  = ins[15:12];
    ext = ins[7:4];
    case (op)
      4'h0: case (ext)
              4'h5: return "ADD";  4'h9: return "SUB";  4'hB: return "CMP";
              4'h1: return "AND";  4'h2: return "OR";   4'h3: return "XOR";
              4'hD: return "MOV";
              default: return "ILLEGAL";
            endcase
      4'h5: return "ADDI"; 4'h9: return "SUBI"; 4'hB: return "CMPI";
      4'h1: return "ANDI"; 4'h2: return "ORI";  4'h3: return "XORI";
      4'hD: return "MOVI"; 4'hF: return "LUI";
      4'h4: case (ext)
              4'h0: return "LOAD"; 4'h4: return "STOR";
              4'hC: return "JCOND"; 4'h8: return "JAL";
              default: return "ILLEGAL";
            endcase
      4'hC: return "BCOND";
      default: return "ILLEGAL";
    endcase
  endfunction

  function automatic bit cond_true(input logic [3:0] c, input logic [4:0] fl);
    bit n, z, cy;
    n  = fl[4];
    z  = fl[3];
    cy = fl[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd6:  return n;
      4'd7:  return !n;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t exec_outs(input string m);
    outs_t o;
    bit    imm;
    string base;
    o   = '0;
    imm = (m.len() > 3 && m.getc(m.len() - 1) == "I") || (m == "ORI");
    base = imm ? m.substr(0, m.len() - 2) : m;
    o.regdst  = 1'b1;
    o.alusrcb = imm ? 2'b01 : 2'b00;
    case (base)
      "ADD": o.alucont = 3'b000;
      "SUB": o.alucont = 3'b001;
      "AND": o.alucont = 3'b010;
      "OR":  o.alucont = 3'b011;
      "XOR": o.alucont = 3'b100;
      "MOV": o.alucont = 3'b101;
      "CMP": o.alucont = 3'b110;
      default: o.alucont = 3'b111;
    endcase
    if (m == "LUI") begin
      o.alucont = 3'b101;
      o.alusrcb = 2'b11;
    end
    o.im_mux  = (m == "ANDI") || (m == "ORI") || (m == "XORI");
    o.flag_en = (base == "ADD") || (base == "SUB") || (base == "CMP");
    o.regwrt  = (base != "CMP");
    return o;
  endfunction

  // ---------------- stimulus ----------------

  task automatic drive_cycle(input logic mr, input outs_t o, input string tag);
    sb_entry_t s;
    mem_ready = mr;
    s.o   = o;
    s.ret = ret_m;
    s.tag = tag;
    sb.push_back(s);
    @(posedge clk);
    #1;
  endtask

  // kind 0 = instruction fetch, 1 = load data, 2 = store data
  task automatic wait_phase(input int kind, input int delay, output bit ok);
    outs_t o;
    ok = 1'b0;
    for (int k = 0; k <= WL; k++) begin
      o = '0;
      if (kind == 0) begin
        o.memread = 1'b1;
        o.alusrcb = 2'b10;
      end else if (kind == 1) begin
        o.memread = 1'b1;
        o.pc_mux  = 1'b1;
      end else begin
        o.memwrite = 1'b1;
        o.pc_mux   = 1'b1;
      end
      if (k == delay) begin
        if (kind == 0) begin
          o.irwrite = 1'b1;
          o.pcen    = 1'b1;
        end
        drive_cycle(1'b1, o, "mem_done");
        ok = 1'b1;
        return;
      end
      if (k == WL) begin
        o.mem_err = 1'b1;
        drive_cycle(1'b0, o, "mem_timeout");
        return;
      end
      drive_cycle(1'b0, o, "mem_wait");
    end
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [4:0] fl,
                           input int fdelay, input int ddelay);
    outs_t o;
    bit    ok, t;
    string m;
    instr = ins;
    flag  = fl;
    wait_phase(0, fdelay, ok);
    while (!ok) wait_phase(0, 0, ok);
    m = mnem(ins);
    o = '0;
    o.illegal = (m == "ILLEGAL");
    drive_cycle(1'($urandom_range(0, 1)), o, "decode");
    if (m == "ILLEGAL") return;
    t = cond_true(ins[11:8], fl);
    o = '0;
    case (m)
      "LOAD": begin
        wait_phase(1, ddelay, ok);
        if (ok) begin
          o.regwrt   = 1'b1;
          o.memtoreg = 1'b1;
          o.regdst   = 1'b1;
          drive_cycle(1'($urandom_range(0, 1)), o, "ld_wb");
          ret_m = ret_m + 1'b1;
        end
      end
      "STOR": begin
        wait_phase(2, ddelay, ok);
        if (ok) ret_m = ret_m + 1'b1;
      end
      "BCOND": begin
        o.branch = t;
        o.pcen   = t;
        drive_cycle(1'($urandom_range(0, 1)), o, "branch");
        ret_m = ret_m + 1'b1;
      end
      "JCOND": begin
        o.jump = t;
        o.pcen = t;
        drive_cycle(1'($urandom_range(0, 1)), o, "jcond");
        ret_m = ret_m + 1'b1;
      end
      "JAL": begin
        o.jal    = 1'b1;
        o.regwrt = 1'b1;
        o.regdst = 1'b1;
        o.jump   = 1'b1;
        o.pcen   = 1'b1;
        drive_cycle(1'($urandom_range(0, 1)), o, "jal");
        ret_m = ret_m + 1'b1;
      end
      default: begin
        drive_cycle(1'($urandom_range(0, 1)), exec_outs(m), {"exec_", m});
        ret_m = ret_m + 1'b1;
      end
    endcase
  endtask

  // Reset arriving mid-load: access abandoned, counter cleared
  task automatic reset_mid_load();
    outs_t o;
    bit    ok;
    instr = 16'h4104;
    wait_phase(0, 0, ok);
    o = '0;
    drive_cycle(1'b0, o, "decode");
    o.memread = 1'b1;
    o.pc_mux  = 1'b1;
    drive_cycle(1'b0, o, "mem_wait");
    drive_cycle(1'b0, o, "mem_wait");
    reset = 1'b1;
    drive_cycle(1'b1, '0, "mid_reset");
    reset = 1'b0;
    ret_m = '0;
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return WL;
    if (r == 1) return 99;
    return $urandom_range(0, 4);
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [15:0] ins;
    logic [3:0]  ops[11];
    logic [3:0]  exts[11];
    ops  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hB, 4'hC, 4'hD, 4'hF};
    exts = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB, 4'hC, 4'hD};
    ins = 16'($urandom);
    if ($urandom_range(0, 3) != 0) ins[15:12] = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 3) != 0) ins[7:4]   = exts[$urandom_range(0, 10)];
    return ins;
  endfunction

  // ---------------- monitor ----------------

  // Pops one expected cycle per clock and compares away from the active edge
  initial begin
    sb_entry_t s;
    outs_t     act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        s   = sb.pop_front();
        act = {pcen, irwrite, regwrt, flag_en, memread, memwrite, memtoreg, regdst,
               pc_mux, im_mux, alusrcb, alucont, branch, jump, jal, illegal, mem_err};
        checks++;
        if (act !== s.o) begin
          failures++;
          $display("FAIL outputs[%s] t=%0t instr=%h actual=%h required=%h",
                   s.tag, $time, instr, act, s.o);
        end
        checks++;
        if (retired !== s.ret) begin
          failures++;
          $display("FAIL retired[%s] t=%0t actual=%0d required=%0d",
                   s.tag, $time, retired, s.ret);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL run_timeout sb_pending=%0d required=0", sb.size());
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit reached");
  end

  // ---------------- main sequence ----------------

  initial begin
    checks    = 0;
    failures  = 0;
    ret_m     = '0;
    reset     = 1'b1;
    instr     = '0;
    flag      = '0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, '0, "in_reset");
    reset = 1'b0;

    run_instr(16'h0253, 5'b00000, 0, 0);
    run_instr(16'h4104, 5'b00000, 1, 3);
    run_instr(16'hC0FE, 5'b01000, 0, 0);
    run_instr(16'hC0FE, 5'b00000, 2, 0);
    run_instr(16'h4586, 5'($urandom), 0, 0);
    run_instr(16'h4243, 5'b00000, 0, 99);
    run_instr(16'hE000, 5'b00000, 0, 0);
    run_instr(16'h4243, 5'b00000, 0, WL);
    run_instr(16'h0253, 5'b00000, WL, 0);
    run_instr(16'h5123, 5'b00000, 99, 0);
    run_instr(16'h4104, 5'b00000, 0, 99);
    run_instr(16'hF1AB, 5'b00000, 0, 0);
    run_instr(16'h1134, 5'b00000, 0, 0);
    run_instr(16'h4EC7, 5'b10000, 0, 0);
    reset_mid_load();
    run_instr(16'h0BB3, 5'b00000, 0, 0);

    for (int n = 0; n < 300; n++) begin
      run_instr(rand_instr(), 5'($urandom), pick_delay(), pick_delay());
    end

    for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cr16_control_fsm.md
Name: cr16_control_fsm

Overview:
- Multicycle control unit that sequences the CR16-style 16-bit datapath.
- Decodes the instruction register and flags, and drives every datapath enable and mux select: PC, IR, register file, ALU, memory.
- Sits between the datapath and the unified instruction/data memory, and owns the memory-ready handshake.
- Keeps a retired-instruction counter and a memory-timeout watchdog.

Parameters:
- WAIT_LIMIT, 15: maximum cycles spent waiting for mem_ready before the access is abandoned.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- instr  in  16  IR contents. Fields: op=[15:12], cond/rdest=[11:8], ext=[7:4], rsrc=[3:0].
- flag  in  5  PSR flags {N,Z,F,L,C} = flag[4:0].
- mem_ready  in  1  memory has accepted the write or returned read data this cycle.
- pcen  out  1  PC register load.
- irwrite  out  1  IR load from memdata.
- regwrt  out  1  register file write.
- flag_en  out  1  PSR flag update.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- memtoreg  out  1  writeback source is memdata (1) or ALU (0).
- regdst  out  1  write register is rdest (1) or rsrc (0).
- pc_mux  out  1  memory address is PC (0) or Rsrc (1).
- im_mux  out  1  immediate is zero-extended (1) or sign-extended (0).
- alusrcb  out  2  ALU B: 00 = Rsrc, 01 = immediate, 10 = constant 1, 11 = immediate<<8.
- alucont  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSB, 110 CMP, 111 reserved.
- branch  out  1  PC ← PC + sext(disp8).
- jump  out  1  PC ← Rsrc.
- jal  out  1  writes PC into rdest.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- mem_err  out  1  one-cycle pulse on watchdog expiry.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset: state = FETCH; wait counter = 0; retired = 0; all single-bit outputs 0; alusrcb = 00; alucont = 000. A reset mid-access abandons the access with no PC/IR/register update.
- States: FETCH, DECODE, EXEC, LD_WAIT, LD_WB, ST_WAIT, BRANCH, JUMP. The state register is one-hot-safe; any illegal encoding goes to FETCH.
- FETCH:
  - memread = 1, pc_mux = 0, alusrcb = 10, alucont = ADD.
  - On mem_ready: irwrite = 1 and pcen = 1 (PC+1) in the same cycle, then go to DECODE.
- DECODE: one cycle, all outputs 0.
  - op 0000 with ext ∈ {0101,1001,1011,0001,0010,0011,1101}, or op ∈ {0101,1001,1011,0001,0010,0011,1101,1111} → EXEC.
  - op 0100 with ext 0000 → LD_WAIT; ext 0100 → ST_WAIT; ext 1100 or 1000 → JUMP.
  - op 1100 → BRANCH.
  - Anything else: illegal = 1, return to FETCH, retired unchanged.
- EXEC: one cycle.
  - alucont from ext (R-type) or op (immediate); LUI (op 1111) uses PASSB with alusrcb = 11.
  - alusrcb = 00 for R-type, 01 for immediate.
  - im_mux = 1 for ANDI/ORI/XORI, otherwise 0.
  - regdst = 1; flag_en = 1 for ADD/SUB/CMP and their immediate forms.
  - regwrt = 1 except CMP/CMPI.
  - Next state FETCH.
- LD_WAIT: memread = 1, pc_mux = 1; on mem_ready → LD_WB.
- LD_WB: regwrt = 1, memtoreg = 1, regdst = 1; then → FETCH.
- ST_WAIT: memwrite = 1, pc_mux = 1; on mem_ready → FETCH.
- Condition (cond field):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0110 GT N; 0111 LE !N; 1100 LT !N&!Z; 1101 GE N|Z.
  - 1110 UC 1; all others 0.
- BRANCH: if cond true then branch = 1 and pcen = 1. One cycle, then → FETCH.
- JUMP: Jcond asserts jump = 1 and pcen = 1 when cond is true. JAL (ext 1000) is unconditional: jal = 1, regwrt = 1, regdst = 1, jump = 1, pcen = 1. One cycle, then → FETCH.
- Watchdog:
  - Counter clears on entry to FETCH, LD_WAIT or ST_WAIT, and increments each cycle mem_ready = 0 in those states.
  - At count = WAIT_LIMIT: mem_err = 1, request dropped, next state FETCH, no PC/IR/register update.
  - A mem_ready arriving in the expiry cycle wins (normal completion).
- retired increments by 1 on each exit to FETCH from EXEC, LD_WB, ST_WAIT (completed), BRANCH or JUMP, whether or not a branch/jump is taken. It wraps at 2^CNT_W. No increment on illegal or mem_err.
- Outputs are Moore (state-decoded) except the mem_ready- and cond-gated strobes (irwrite, pcen in FETCH, pcen/branch/jump in BRANCH/JUMP, state exits). Those strobes must settle combinationally within the same cycle.

Decomposition:
- Shared package cr16_pkg holds the opcode, ext, cond and alucont encodings, the alusrcb codes and the flag bit indices.
- One sub-module, cr16_cond_eval (cond[3:0], flag[4:0] → taken), is natural; the datapath's future branch-prediction logic reuses it.

Test Plan:
- Reset held 2 cycles, then released → state FETCH, memread = 1, all other strobes 0, retired = 0.
- ADD R2,R3 (instr 0x0253), mem_ready = 1 in FETCH → DECODE → EXEC with regwrt = 1, flag_en = 1, alucont = 000, alusrcb = 00. retired = 1 after 3 cycles.
- LOAD R1,[R4] (0x4104), mem_ready delayed 3 cycles in LD_WAIT → memread held with pc_mux = 1 for 4 cycles, then LD_WB with memtoreg = 1 and regwrt = 1.
- BEQ (0xC0FE) with Z = 1 → branch = 1, pcen = 1 in BRANCH. With Z = 0 → no pcen; retired still increments.
- JAL R5,R6 (0x4586) → jal, jump, regwrt and pcen all 1 for exactly one cycle.
- mem_ready held 0 in ST_WAIT → after WAIT_LIMIT = 15 cycles, mem_err pulses, FSM returns to FETCH, retired unchanged. Opcode 0xE000 → illegal pulse.
